// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: FSM encoding, source ids and status-bit positions for the TX scheduler
package uart_tx_sched_pkg;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACT, WAIT_DONE} state_t;
   typedef enum logic {SRC_FIFO, SRC_ECHO} src_t;
   localparam int STAT_FIFO_FULL = 0;
   localparam int STAT_OVERFLOW  = 1;
   localparam int STAT_ECHO_DROP = 2;
endpackage

// File: rtl/sync_fifo_8b.sv
// sync_fifo_8b: byte FIFO with first-word-fall-through read data and registered status
module sync_fifo_8b #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr,
   input  logic                     rd,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic          do_wr, do_rd;
   logic [AW:0]   count_nx;
   assign do_rd    = rd && !empty;
   // a full FIFO still takes a write when the head leaves in the same cycle
   assign do_wr    = wr && (!full || do_rd);
   assign count_nx = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
   assign rdata    = mem[rptr];
   always_ff @(posedge clk)
      if (do_wr) mem[wptr] <= wdata;
   always_ff @(posedge clk)
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         wptr  <= wptr + AW'(do_wr);
         rptr  <= rptr + AW'(do_rd);
         count <= count_nx;
         full  <= count_nx == (AW+1)'(DEPTH);
         empty <= count_nx == '0;
      end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin sharing of one uart_tx between the CPU byte FIFO and the RX echo register
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int ACK_TIMEOUT = 4,
   parameter bit ECHO_EN     = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   input  logic                          echo_valid,
   input  logic [7:0]                    echo_data,
   input  logic                          stat_clr,
   input  logic                          TX_STATUS,
   output logic                          TX_EN,
   output logic [7:0]                    TX_DATA,
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          echo_drop,
   output logic                          busy
);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   state_t        state;
   src_t          last, sel;
   logic [CW-1:0] cnt;
   logic [7:0]    fifo_data, echo_q;
   logic          echo_v, grant, pop_fifo, pop_echo, echo_cap, ovf_evt, drop_evt;
   sync_fifo_8b #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (wr_en),
      .rd    (pop_fifo),
      .wdata (wr_data),
      .rdata (fifo_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );
   assign sel      = (!fifo_empty && echo_v) ? (last == SRC_FIFO ? SRC_ECHO : SRC_FIFO)
                                             : (echo_v ? SRC_ECHO : SRC_FIFO);
   assign grant    = state == IDLE && !TX_STATUS && (!fifo_empty || echo_v);
   assign pop_fifo = grant && sel == SRC_FIFO;
   assign pop_echo = grant && sel == SRC_ECHO;
   assign echo_cap = ECHO_EN && echo_valid;
   assign ovf_evt  = wr_en && fifo_full && !pop_fifo;
   assign drop_evt = echo_cap && echo_v && !pop_echo;
   assign busy     = state != IDLE || !fifo_empty || echo_v;
   always_ff @(posedge clk)
      if (reset) begin
         state     <= IDLE;
         last      <= SRC_ECHO;
         cnt       <= '0;
         TX_EN     <= 1'b0;
         TX_DATA   <= '0;
         echo_v    <= 1'b0;
         echo_q    <= '0;
         overflow  <= 1'b0;
         echo_drop <= 1'b0;
      end else begin
         TX_EN     <= 1'b0;
         overflow  <= ovf_evt || (overflow && !stat_clr);
         echo_drop <= drop_evt || (echo_drop && !stat_clr);
         if (echo_cap && (!echo_v || pop_echo)) begin
            echo_v <= 1'b1;
            echo_q <= echo_data;
         end else if (pop_echo)
            echo_v <= 1'b0;
         case (state)
            IDLE:
               if (grant) begin
                  TX_DATA <= sel == SRC_ECHO ? echo_q : fifo_data;
                  last    <= sel;
                  TX_EN   <= 1'b1;
                  state   <= LAUNCH;
               end
            LAUNCH: begin
               cnt   <= '0;
               state <= WAIT_ACT;
            end
            // no acknowledge within ACK_TIMEOUT cycles: relaunch the byte already held in TX_DATA
            WAIT_ACT:
               if (TX_STATUS)
                  state <= WAIT_DONE;
               else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                  TX_EN <= 1'b1;
                  state <= LAUNCH;
               end else
                  cnt <= cnt + 1'b1;
            WAIT_DONE:
               if (!TX_STATUS) state <= IDLE;
            default:
               state <= IDLE;
         endcase
      end
endmodule
